pipelined_control_unit: RTL and testbench

//  Registered successor of the combinational MIPS control decoder, generalised in bus and field widths.

---
 rtl/pipelined_control_unit.sv | 217 +++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: registered MIPS control decoder with load-use stall, flush and HALT drain sequencing
// Sits between IF/ID and ID/EX; decodes the ID instruction into EX/MEM/WB control
// buses registered into ID/EX, and drives the PC and IF/ID write/flush controls.
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   i_valid                    IF/ID holds a valid instruction
//   i_opcode, i_funct          instr[31:26], instr[5:0]
//   i_rs, i_rt                 instr[25:21], instr[20:16]
//   i_idex_mem_read, i_idex_rt load currently in ID/EX and its destination
//   i_branch_taken             branch resolved taken in EX this cycle
//   o_execute_bus              registered {reg_dst, alu_src, alu_op}
//   o_memory_bus               registered {branch, mem_read, mem_write}
//   o_wb_bus                   registered {reg_write, mem_to_reg}
//   o_valid                    registered; ID/EX holds a real instruction
//   o_jump                     jump in ID is taken, select jump target
//   o_pc_write, o_ifid_write   PC and IF/ID write enables
//   o_ifid_flush               clear IF/ID on next edge
//   o_halted                   pipeline drained after HALT
module pipelined_control_unit #(
    parameter int EXEC_BUS_WIDTH = 6,
    parameter int MEM_BUS_WIDTH  = 3,
    parameter int WB_BUS_WIDTH   = 2,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_valid,
    input  logic [5:0]                i_opcode,
    input  logic [5:0]                i_funct,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_rt,
    input  logic                      i_idex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] i_idex_rt,
    input  logic                      i_branch_taken,
    output logic [EXEC_BUS_WIDTH-1:0] o_execute_bus,
    output logic [MEM_BUS_WIDTH-1:0]  o_memory_bus,
    output logic [WB_BUS_WIDTH-1:0]   o_wb_bus,
    output logic                      o_valid,
    output logic                      o_jump,
    output logic                      o_pc_write,
    output logic                      o_ifid_write,
    output logic                      o_ifid_flush,
    output logic                      o_halted
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [EXEC_BUS_WIDTH-1:0] ex_q, ex_d;
    logic [MEM_BUS_WIDTH-1:0]  mem_q, mem_d;
    logic [WB_BUS_WIDTH-1:0]   wb_q, wb_d;
    logic                      valid_q, issue;
    logic [3:0]                alu_code;
    logic                      alu_src, reg_dst, mem_write, mem_read, branch;
    logic                      mem_to_reg, reg_write, is_jump, rt_used;
    logic                      halt, stall;

    function automatic logic [3:0] r_alu(input logic [5:0] f);
        r_alu = 4'hF;
        case (f)
            6'b000000, 6'b000100: r_alu = 4'b0000;
            6'b000010, 6'b000110: r_alu = 4'b0001;
            6'b000011, 6'b000111: r_alu = 4'b0010;
            6'b100000, 6'b100001: r_alu = 4'b0011;
            6'b100010, 6'b100011: r_alu = 4'b1000;
            6'b100100:            r_alu = 4'b0100;
            6'b100101:            r_alu = 4'b0101;
            6'b100110:            r_alu = 4'b0110;
            6'b100111:            r_alu = 4'b0111;
            6'b101010:            r_alu = 4'b1001;
            default:              r_alu = 4'hF;
        endcase
    endfunction

    // ADDIU shares the ADD code; SLTIU has no code of its own and falls to 1111
    function automatic logic [3:0] i_alu(input logic [2:0] op);
        i_alu = 4'hF;
        case (op)
            3'b000, 3'b001: i_alu = 4'b0011;
            3'b010:         i_alu = 4'b1001;
            3'b100:         i_alu = 4'b0100;
            3'b101:         i_alu = 4'b0101;
            3'b110:         i_alu = 4'b0110;
            3'b111:         i_alu = 4'b1010;
            default:        i_alu = 4'hF;
        endcase
    endfunction

    always_comb begin
        alu_code   = 4'hF;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        branch     = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        is_jump    = 1'b0;
        rt_used    = 1'b0;
        casez (i_opcode)
            6'b000000: begin
                reg_dst   = 1'b1;
                reg_write = i_funct != 6'b001000;
                rt_used   = 1'b1;
                is_jump   = i_funct[5:1] == 5'b00100;
                alu_code  = r_alu(i_funct);
            end
            6'b001???: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                alu_code  = i_alu(i_opcode[2:0]);
            end
            6'b100???: begin
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                alu_code   = 4'b0011;
            end
            6'b101???: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                rt_used   = 1'b1;
                alu_code  = 4'b0011;
            end
            6'b00010?: begin
                branch   = 1'b1;
                rt_used  = 1'b1;
                alu_code = 4'b1000;
            end
            6'b00001?: begin
                is_jump   = 1'b1;
                reg_write = i_opcode[0];
            end
            default: ;
        endcase
    end

    assign halt  = i_valid && i_opcode == 6'b111111;
    assign stall = i_valid && i_idex_mem_read && |i_idex_rt &&
                   (i_idex_rt == i_rs || (rt_used && i_idex_rt == i_rt));

    // The counter holds cycles elapsed since the HALT edge; HALTED is reached
    // so that o_halted rises DRAIN_CYCLES edges after HALT was presented.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
        o_ifid_flush = 1'b0;
        o_jump       = 1'b0;
        issue        = 1'b0;
        if (state_q == RUN) begin
            if (i_branch_taken) begin
                o_pc_write   = 1'b1;
                o_ifid_write = 1'b1;
                o_ifid_flush = 1'b1;
            end else if (stall) begin
                issue = 1'b0;
            end else if (halt) begin
                state_d = (DRAIN_CYCLES <= 1) ? HALTED : DRAIN;
                cnt_d   = CW'(1);
            end else begin
                o_pc_write   = 1'b1;
                o_ifid_write = 1'b1;
                issue        = i_valid;
                o_jump       = i_valid && is_jump;
                o_ifid_flush = i_valid && is_jump;
            end
        end else if (state_q == DRAIN) begin
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(DRAIN_CYCLES - 1)) ? HALTED : DRAIN;
        end
    end

    always_comb begin
        ex_d                   = '0;
        mem_d                  = '0;
        wb_d                   = '0;
        ex_d[ALU_OP_WIDTH-1:0] = ALU_OP_WIDTH'(alu_code);
        ex_d[ALU_OP_WIDTH]     = alu_src;
        ex_d[ALU_OP_WIDTH+1]   = reg_dst;
        mem_d[0]               = mem_write;
        mem_d[1]               = mem_read;
        mem_d[2]               = branch;
        wb_d[0]                = mem_to_reg;
        wb_d[1]                = reg_write;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= issue ? ex_d : '0;
            mem_q   <= issue ? mem_d : '0;
            wb_q    <= issue ? wb_d : '0;
            valid_q <= issue;
        end
    end

    assign o_execute_bus = ex_q;
    assign o_memory_bus  = mem_q;
    assign o_wb_bus      = wb_q;
    assign o_valid       = valid_q;
    assign o_halted      = state_q == HALTED;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed and randomized checks of pipelined_control_unit against a behavioural model
module tb_pipelined_control_unit;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_valid = 1'b0;
    logic [5:0] i_opcode = '0;
    logic [5:0] i_funct = '0;
    logic [4:0] i_rs = '0;
    logic [4:0] i_rt = '0;
    logic       i_idex_mem_read = 1'b0;
    logic [4:0] i_idex_rt = '0;
    logic       i_branch_taken = 1'b0;
    logic [5:0] o_execute_bus;
    logic [2:0] o_memory_bus;
    logic [1:0] o_wb_bus;
    logic       o_valid, o_jump, o_pc_write, o_ifid_write, o_ifid_flush, o_halted;

    pipelined_control_unit dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_opcode(i_opcode), .i_funct(i_funct),
        .i_rs(i_rs), .i_rt(i_rt), .i_idex_mem_read(i_idex_mem_read), .i_idex_rt(i_idex_rt),
        .i_branch_taken(i_branch_taken), .o_execute_bus(o_execute_bus), .o_memory_bus(o_memory_bus),
        .o_wb_bus(o_wb_bus), .o_valid(o_valid), .o_jump(o_jump), .o_pc_write(o_pc_write),
        .o_ifid_write(o_ifid_write), .o_ifid_flush(o_ifid_flush), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] alu;
        logic src, dst, mw, mr, br, m2r, rw, jmp, rtu;
    } ctl_t;

    int n_cmp = 0;
    int n_bad = 0;
    int age = -1;
    logic [5:0] ops[$] = '{0, 0, 0, 8, 9, 10, 11, 12, 13, 14, 15, 32, 35, 40, 43, 4, 5, 2, 3, 1, 16, 62};
    logic [5:0] fns[$] = '{0, 2, 3, 4, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42, 8, 9, 1, 43};

    function automatic ctl_t model(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c = '0;
        c.alu = 4'hF;
        if (op == 0) begin
            c.dst = 1; c.rtu = 1; c.rw = (fn != 8); c.jmp = (fn == 8 || fn == 9);
            case (fn)
                0, 4: c.alu = 0;   2, 6: c.alu = 1;   3, 7: c.alu = 2;
                32, 33: c.alu = 3; 34, 35: c.alu = 8; 36: c.alu = 4;
                37: c.alu = 5;     38: c.alu = 6;     39: c.alu = 7;
                42: c.alu = 9;     default: c.alu = 4'hF;
            endcase
        end else if (op >= 8 && op <= 15) begin
            c.src = 1; c.rw = 1;
            case (op)
                8, 9: c.alu = 3; 10: c.alu = 9; 12: c.alu = 4;
                13: c.alu = 5;   14: c.alu = 6; 15: c.alu = 10;
                default: c.alu = 4'hF;
            endcase
        end else if (op >= 32 && op <= 39) begin
            c.alu = 3; c.src = 1; c.mr = 1; c.m2r = 1; c.rw = 1;
        end else if (op >= 40 && op <= 47) begin
            c.alu = 3; c.src = 1; c.mw = 1; c.rtu = 1;
        end else if (op == 4 || op == 5) begin
            c.alu = 8; c.br = 1; c.rtu = 1;
        end else if (op == 2 || op == 3) begin
            c.jmp = 1; c.rw = (op == 3);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic mr, input logic [4:0] irt, input logic bt);
        i_valid = v; i_opcode = op; i_funct = fn; i_rs = rs; i_rt = rt;
        i_idex_mem_read = mr; i_idex_rt = irt; i_branch_taken = bt;
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic tick();
        ctl_t c;
        logic haz, e_pc, e_ifw, e_fl, e_j, issue;
        int next_age;
        #1;
        c = model(i_opcode, i_funct);
        haz = i_valid && i_idex_mem_read && i_idex_rt != 0 &&
              (i_idex_rt == i_rs || (c.rtu && i_idex_rt == i_rt));
        {e_pc, e_ifw, e_fl, e_j, issue} = '0;
        next_age = age;
        if (age >= 0) next_age = age + 1;
        else if (i_branch_taken) {e_pc, e_ifw, e_fl} = 3'b111;
        else if (haz) next_age = -1;
        else if (i_valid && i_opcode == 6'd63) next_age = 1;
        else begin
            e_pc = 1; e_ifw = 1; issue = i_valid;
            e_j = i_valid && c.jmp; e_fl = e_j;
        end
        chk("pc_write", o_pc_write, e_pc);
        chk("ifid_write", o_ifid_write, e_ifw);
        chk("ifid_flush", o_ifid_flush, e_fl);
        chk("jump", o_jump, e_j);
        @(posedge clk);
        #1;
        if (reset) begin
            age = -1; issue = 0;
        end else age = next_age;
        chk("execute_bus", o_execute_bus, issue ? {c.dst, c.src, c.alu} : 6'd0);
        chk("memory_bus", o_memory_bus, issue ? {c.br, c.mr, c.mw} : 3'd0);
        chk("wb_bus", o_wb_bus, issue ? {c.rw, c.m2r} : 2'd0);
        chk("valid", o_valid, issue);
        chk("halted", o_halted, age >= DC);
        @(negedge clk);
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        tick();
        tick();
        chk("rst_exec", o_execute_bus, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_halted", o_halted, 0);
        chk("rst_pc_write", o_pc_write, 1);
        reset = 1'b0;

        set_in(1, 6'b000000, 6'b100001, 1, 2, 0, 0, 0);
        tick();
        chk("addu_exec", o_execute_bus, 6'b100011);
        chk("addu_wb", o_wb_bus, 2'b10);
        set_in(1, 6'b100011, 0, 3, 4, 0, 0, 0);
        tick();
        chk("lw_exec", o_execute_bus, 6'b010011);
        chk("lw_mem", o_memory_bus, 3'b010);
        chk("lw_wb", o_wb_bus, 2'b11);

        set_in(1, 6'b000000, 6'b100000, 5, 6, 1, 5, 0);
        #1;
        chk("stall_pc", o_pc_write, 0);
        chk("stall_ifid", o_ifid_write, 0);
        tick();
        chk("stall_bubble", o_valid, 0);
        set_in(1, 6'b000000, 6'b100000, 0, 6, 1, 0, 0);
        #1;
        chk("rt0_pc", o_pc_write, 1);
        tick();
        chk("rt0_valid", o_valid, 1);

        set_in(1, 6'b000000, 6'b100000, 5, 6, 1, 5, 1);
        #1;
        chk("bt_flush", o_ifid_flush, 1);
        chk("bt_pc", o_pc_write, 1);
        tick();
        chk("bt_bubble", o_valid, 0);

        set_in(1, 6'b000010, 0, 0, 0, 0, 0, 0);
        #1;
        chk("j_jump", o_jump, 1);
        chk("j_flush", o_ifid_flush, 1);
        tick();
        chk("j_valid", o_valid, 1);
        set_in(1, 6'b000101, 0, 1, 2, 0, 0, 0);
        tick();
        chk("bne_mem", o_memory_bus, 3'b100);
        chk("bne_alu", o_execute_bus[3:0], 4'b1000);

        set_in(1, 6'b111111, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0);
        for (int i = 1; i < DC; i++) begin
            #1;
            chk("drain_pc", o_pc_write, 0);
            chk("drain_halted", o_halted, 0);
            tick();
        end
        chk("halted_rise", o_halted, 1);
        chk("halted_pc", o_pc_write, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        set_in(1, 6'b111111, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_in(1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0);
        for (int i = 0; i < DC + 1; i++) tick();
        chk("mid_rst_halted", o_halted, 0);
        chk("mid_rst_pc", o_pc_write, 1);

        for (int n = 0; n < 600; n++) begin
            logic [5:0] op;
            reset = (age >= DC + 2) || $urandom_range(0, 49) == 0;
            op = ops[$urandom_range(0, ops.size() - 1)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            if ($urandom_range(0, 59) == 0) op = 6'd63;
            set_in($urandom_range(0, 7) != 0, op, fns[$urandom_range(0, fns.size() - 1)],
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
